// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program counter and return-address stack for the MUSA core. The architectural
// PC advances once per committed instruction (write_pc high while not halted).
// The next PC is chosen by the control unit's branch code, by the ret path
// (pop + add_pc) and by the brfl conditional branch. A LIFO of STACK_DEPTH
// entries holds return addresses. It reports full/empty status and keeps
// sticky overflow and underflow flags.
//
// Parameters
//   PC_WIDTH     width of the PC and of the jump targets
//   STACK_DEPTH  number of return-stack entries (power of two, >= 2)
//   RESET_PC     PC value loaded at reset
//
// Ports
//   clk              system clock, rising edge
//   rst_n            asynchronous active-low reset
//   write_pc         instruction-commit strobe
//   branch[2:0]      000 seq, 001 jr, 010 call, 011 halt, 100 jpc, others = seq
//   push / pop       return-stack push / pop
//   add_pc           together with pop: ret, next PC = popped value + 1
//   brfl_control     conditional branch instruction
//   flag_true        ALU compare result for brfl
//   reg_target       jr target from the register file
//   imm_target       jpc / call / brfl target from the instruction word
//   pc               current PC (registered)
//   halted           sticky halt status (registered)
//   stack_empty      no valid entries
//   stack_full       STACK_DEPTH valid entries
//   stack_overflow   sticky: a push was attempted while full
//   stack_underflow  sticky: a pop was attempted while empty
//   stack_count      number of valid entries
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int                     PC_WIDTH    = 32,
    parameter int                     STACK_DEPTH = 8,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           write_pc,
    input  logic [2:0]                     branch,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           add_pc,
    input  logic                           brfl_control,
    input  logic                           flag_true,
    input  logic [PC_WIDTH-1:0]            reg_target,
    input  logic [PC_WIDTH-1:0]            imm_target,
    output logic [PC_WIDTH-1:0]            pc,
    output logic                           halted,
    output logic                           stack_empty,
    output logic                           stack_full,
    output logic                           stack_overflow,
    output logic                           stack_underflow,
    output logic [$clog2(STACK_DEPTH):0]   stack_count
);

    localparam int AW = $clog2(STACK_DEPTH);  // stack index width
    localparam int CW = AW + 1;               // count width, holds 0..STACK_DEPTH

    localparam logic [2:0] BR_JR   = 3'b001;
    localparam logic [2:0] BR_CALL = 3'b010;
    localparam logic [2:0] BR_HALT = 3'b011;
    localparam logic [2:0] BR_JPC  = 3'b100;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                state_q,  state_d;
    logic [PC_WIDTH-1:0]   pc_q,     pc_d;
    logic [CW-1:0]         count_q,  count_d;
    logic                  ovf_q,    ovf_d;
    logic                  unf_q,    unf_d;

    logic [PC_WIDTH-1:0]   mem [STACK_DEPTH];
    logic                  mem_we;
    logic [AW-1:0]         mem_waddr;
    logic [PC_WIDTH-1:0]   mem_wdata;

    // ------------------------------------------------------------------
    // Decode from registered state only
    // ------------------------------------------------------------------
    logic                  empty;
    logic                  full;
    logic                  commit;
    logic [AW-1:0]         top_idx;
    logic [PC_WIDTH-1:0]   top_val;
    logic [PC_WIDTH-1:0]   pc_inc;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(STACK_DEPTH));
    assign commit  = write_pc && (state_q == S_RUN);
    // When the stack is empty this index wraps. That is harmless because
    // top_val is only used when the stack is not empty.
    assign top_idx = AW'(count_q - CW'(1));
    assign top_val = mem[top_idx];
    assign pc_inc  = pc_q + PC_WIDTH'(1);  // wraps modulo 2^PC_WIDTH

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the
        // branches below can leave a value unassigned and infer a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        mem_we    = 1'b0;
        mem_waddr = count_q[AW-1:0];
        mem_wdata = pc_q;

        if (commit) begin
            if (branch == BR_HALT) begin
                // Halt has top priority. The PC and the stack are frozen.
                state_d = S_HALT;
            end else begin
                // Stack update. It is independent of the PC choice below.
                if (push && pop && !empty) begin
                    // Replace the top entry. The depth stays the same.
                    mem_we    = 1'b1;
                    mem_waddr = top_idx;
                end else if (push) begin
                    // This also covers push+pop on an empty stack.
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        mem_we    = 1'b1;
                        mem_waddr = count_q[AW-1:0];
                        count_d   = count_q + CW'(1);
                    end
                end else if (pop) begin
                    if (empty) begin
                        unf_d = 1'b1;
                    end else begin
                        count_d = count_q - CW'(1);
                    end
                end

                // Next-PC priority
                if (pop && add_pc) begin
                    pc_d = empty ? pc_inc : (top_val + PC_WIDTH'(1));
                end else if (branch == BR_CALL) begin
                    pc_d = imm_target;
                end else if (branch == BR_JR) begin
                    pc_d = reg_target;
                end else if (branch == BR_JPC) begin
                    pc_d = imm_target;
                end else if (brfl_control && flag_true) begin
                    pc_d = imm_target;
                end else begin
                    pc_d = pc_inc;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // NOTE: the stack RAM has no reset on purpose. Entries at or above
    // count_q can never be read back, so clearing them would add reset
    // fan-out for no benefit. Leaving out the reset also lets the array map
    // to plain storage.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pc              = pc_q;
    assign halted          = (state_q == S_HALT);
    assign stack_empty     = empty;
    assign stack_full      = full;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;
    assign stack_count     = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed testbench for pc_sequencer (PC_WIDTH=32, STACK_DEPTH=8, RESET_PC=0).
// It runs one linear sequence of commits. Expected values are computed by hand,
// and each one is compared with an immediate assertion.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        write_pc;
    logic [2:0]  branch;
    logic        push;
    logic        pop;
    logic        add_pc;
    logic        brfl_control;
    logic        flag_true;
    logic [31:0] reg_target;
    logic [31:0] imm_target;
    logic [31:0] pc;
    logic        halted;
    logic        stack_empty;
    logic        stack_full;
    logic        stack_overflow;
    logic        stack_underflow;
    logic [3:0]  stack_count;

    int n_checks = 0;
    int n_fail   = 0;

    pc_sequencer #(
        .PC_WIDTH   (32),
        .STACK_DEPTH(8),
        .RESET_PC   (32'h0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .write_pc       (write_pc),
        .branch         (branch),
        .push           (push),
        .pop            (pop),
        .add_pc         (add_pc),
        .brfl_control   (brfl_control),
        .flag_true      (flag_true),
        .reg_target     (reg_target),
        .imm_target     (imm_target),
        .pc             (pc),
        .halted         (halted),
        .stack_empty    (stack_empty),
        .stack_full     (stack_full),
        .stack_overflow (stack_overflow),
        .stack_underflow(stack_underflow),
        .stack_count    (stack_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One commit cycle. Inputs change on the falling edge. Outputs are
    // sampled 1 time unit after the rising edge that performs the commit.
    task automatic commit(input logic [2:0] br, input logic ps, input logic pp,
                          input logic ap, input logic bf, input logic ft,
                          input logic [31:0] rt, input logic [31:0] it);
        @(negedge clk);
        branch       = br;
        push         = ps;
        pop          = pp;
        add_pc       = ap;
        brfl_control = bf;
        flag_true    = ft;
        reg_target   = rt;
        imm_target   = it;
        write_pc     = 1'b1;
        @(posedge clk);
        #1;
        write_pc     = 1'b0;
        branch       = 3'b000;
        push         = 1'b0;
        pop          = 1'b0;
        add_pc       = 1'b0;
        brfl_control = 1'b0;
        flag_true    = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"},    pc,              64'h0);
        check({tag, "_halt"},  halted,          64'h0);
        check({tag, "_cnt"},   stack_count,     64'h0);
        check({tag, "_empty"}, stack_empty,     64'h1);
        check({tag, "_full"},  stack_full,      64'h0);
        check({tag, "_ovf"},   stack_overflow,  64'h0);
        check({tag, "_unf"},   stack_underflow, 64'h0);
    endtask

    initial begin
        logic [31:0] exp_pc;

        rst_n        = 1'b0;
        write_pc     = 1'b0;
        branch       = 3'b000;
        push         = 1'b0;
        pop          = 1'b0;
        add_pc       = 1'b0;
        brfl_control = 1'b0;
        flag_true    = 1'b0;
        reg_target   = 32'h0;
        imm_target   = 32'h0;

        // Reset state
        #2;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch
        for (int i = 1; i <= 4; i++) begin
            commit(3'b000, 0, 0, 0, 0, 0, 32'h0, 32'h0);
            check($sformatf("seq%0d_pc", i), pc, 64'(i));
            check($sformatf("seq%0d_empty", i), stack_empty, 64'h1);
        end

        // A cycle with write_pc low leaves the PC unchanged
        @(negedge clk);
        branch     = 3'b001;
        reg_target = 32'h999;
        @(posedge clk);
        #1;
        branch = 3'b000;
        check("idle_hold_pc", pc, 64'h4);

        // Call / ret
        commit(3'b001, 0, 0, 0, 0, 0, 32'h10, 32'h0);
        check("jr_to_10", pc, 64'h10);
        commit(3'b010, 1, 0, 0, 0, 0, 32'h0, 32'h40);
        check("call_pc", pc, 64'h40);
        check("call_cnt", stack_count, 64'h1);
        commit(3'b000, 0, 1, 1, 0, 0, 32'h0, 32'h0);
        check("ret_pc", pc, 64'h11);
        check("ret_empty", stack_empty, 64'h1);

        // Nine calls. Call k jumps to 0x100 + (k-1)*0x10.
        for (int k = 1; k <= 9; k++) begin
            commit(3'b010, 1, 0, 0, 0, 0, 32'h0, 32'h100 + 32'(k - 1) * 32'h10);
            check($sformatf("call%0d_pc", k), pc, 64'h100 + 64'(k - 1) * 64'h10);
            if (k == 8) begin
                check("call8_full", stack_full, 64'h1);
                check("call8_ovf", stack_overflow, 64'h0);
            end
        end
        check("call9_full", stack_full, 64'h1);
        check("call9_ovf", stack_overflow, 64'h1);
        check("call9_cnt", stack_count, 64'h8);

        // Rets come back in LIFO order. Call 1 pushed 0x11. Call k (2..8)
        // pushed 0x100 + (k-2)*0x10.
        for (int j = 1; j <= 8; j++) begin
            commit(3'b000, 0, 1, 1, 0, 0, 32'h0, 32'h0);
            exp_pc = (j == 8) ? 32'h12 : (32'h100 + 32'(7 - j) * 32'h10 + 32'h1);
            check($sformatf("ret%0d_pc", j), pc, 64'(exp_pc));
            check($sformatf("ret%0d_cnt", j), stack_count, 64'(8 - j));
        end
        check("ret8_unf", stack_underflow, 64'h0);
        commit(3'b000, 0, 1, 1, 0, 0, 32'h0, 32'h0);
        check("ret9_pc", pc, 64'h13);
        check("ret9_unf", stack_underflow, 64'h1);
        check("ret9_empty", stack_empty, 64'h1);
        check("ret9_ovf_sticky", stack_overflow, 64'h1);

        // brfl and jr
        commit(3'b000, 0, 0, 0, 1, 1, 32'h0, 32'h80);
        check("brfl_taken", pc, 64'h80);
        commit(3'b000, 0, 0, 0, 1, 0, 32'h0, 32'h80);
        check("brfl_not_taken", pc, 64'h81);
        commit(3'b001, 0, 0, 0, 0, 0, 32'h200, 32'h0);
        check("jr_200", pc, 64'h200);
        commit(3'b100, 0, 0, 0, 0, 0, 32'h0, 32'h300);
        check("jpc_300", pc, 64'h300);

        // Two pushes, then halt at 0x20
        commit(3'b001, 0, 0, 0, 0, 0, 32'h1E, 32'h0);
        commit(3'b000, 1, 0, 0, 0, 0, 32'h0, 32'h0);
        commit(3'b000, 1, 0, 0, 0, 0, 32'h0, 32'h0);
        check("pre_halt_pc", pc, 64'h20);
        check("pre_halt_cnt", stack_count, 64'h2);
        commit(3'b011, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        check("halt_flag", halted, 64'h1);
        check("halt_pc", pc, 64'h20);
        for (int i = 0; i < 3; i++) begin
            commit(3'b000, 0, 0, 0, 0, 0, 32'h0, 32'h0);
            check($sformatf("halted_hold%0d_pc", i), pc, 64'h20);
        end
        check("halted_still", halted, 64'h1);
        check("halted_cnt", stack_count, 64'h2);

        // Asynchronous reset in the middle of a cycle
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_state("midreset");
        @(negedge clk);
        rst_n = 1'b1;

        // Push+pop on an empty stack acts as a push. Push+pop on a non-empty
        // stack replaces the top entry.
        commit(3'b000, 1, 1, 0, 0, 0, 32'h0, 32'h0);
        check("pp_empty_pc", pc, 64'h1);
        check("pp_empty_cnt", stack_count, 64'h1);
        check("pp_empty_ovf", stack_overflow, 64'h0);
        check("pp_empty_unf", stack_underflow, 64'h0);
        commit(3'b000, 1, 1, 0, 0, 0, 32'h0, 32'h0);
        check("pp_replace_pc", pc, 64'h2);
        check("pp_replace_cnt", stack_count, 64'h1);
        commit(3'b000, 0, 1, 1, 0, 0, 32'h0, 32'h0);
        check("pp_ret_pc", pc, 64'h2);
        check("pp_ret_empty", stack_empty, 64'h1);

        // Pop without add_pc on an empty stack
        commit(3'b000, 0, 1, 0, 0, 0, 32'h0, 32'h0);
        check("pop_empty_pc", pc, 64'h3);
        check("pop_empty_unf", stack_underflow, 64'h1);

        // PC wraps from all-ones to zero
        commit(3'b001, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'h0);
        check("wrap_pre", pc, 64'hFFFF_FFFF);
        commit(3'b000, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        check("wrap_pc", pc, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
